call_registry: RTL
==================

CALL_REGISTRY -- requirements
Module: call_registry

Interface
REQ-001 The block SHALL have parameter FLOORS, default 8, number of served floors (2..16).
REQ-002 The block SHALL have parameter FLOOR_W, default 3, floor index width, with 2**FLOOR_W >= FLOORS.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 cur_floor  input  FLOOR_W  floor the car is at or passing.
REQ-006 door_open  input  1  high while the car doors are open at cur_floor.
REQ-007 cab_btn  input  FLOORS  in-car floor buttons, asynchronous levels.
REQ-008 hall_up_btn  input  FLOORS  hall up buttons; bit FLOORS-1 ignored.
REQ-009 hall_dn_btn  input  FLOORS  hall down buttons; bit 0 ignored.
REQ-010 serve_cab, serve_up, serve_dn  input  1 each  one-cycle pulses clearing the matching call at cur_floor.
REQ-011 cab_calls, up_calls, dn_calls  output  FLOORS each  registered pending-call vectors.
REQ-012 call_above, call_below, call_here  output  1 each  any pending call at index >, <, == cur_floor.
REQ-013 pending_cnt  output  FLOOR_W+2  total set bits across cab_calls, up_calls, dn_calls.

Function
REQ-014 Every button bit SHALL pass through a 2-flop synchroniser followed by one history flop; a press is the synchronised 0->1 transition.
REQ-015 A button high before clk edge k with low history SHALL set its call bit at edge k+2 (visible after edge k+2); a held button SHALL register once.
REQ-016 A press SHALL be ignored when its floor equals cur_floor and door_open is 1 (all three call types).
REQ-017 serve_X with cur_floor < FLOORS SHALL clear bit cur_floor of the matching vector at the next edge; cur_floor >= FLOORS SHALL make serve pulses and blocking no-ops.
REQ-018 Serve clear SHALL take priority over a press on the same bit in the same cycle.
REQ-019 Calls on different bits SHALL update independently in the same cycle.
REQ-020 up_calls[FLOORS-1] and dn_calls[0] SHALL be constant 0.
REQ-021 call_above, call_below, call_here and pending_cnt SHALL be combinational from the call registers and cur_floor; call_here SHALL be 0 when cur_floor >= FLOORS.
REQ-022 pending_cnt SHALL never wrap (maximum 3*FLOORS-2).

Reset
REQ-023 reset low SHALL asynchronously clear all call vectors, synchroniser and history flops to 0.
REQ-024 With reset high again, a button held through reset SHALL register as a press (history starts at 0).
REQ-025 Reset asserted mid-operation SHALL discard all pending calls and any press in flight.

Configuration
REQ-026 Macro CALL_REGISTRY_CAB_CANCEL_EN defined: a press on a cab button whose cab_calls bit is already set SHALL clear that bit at the press edge (toggle); hall calls unaffected.
REQ-027 Macro undefined: a press on an already-set call SHALL leave it set; no cancel path SHALL be synthesised.

Verification
REQ-028 Reset, FLOORS=8, cur_floor=0: pulse cab_btn[5] high 3 cycles -> cab_calls=8'h20 two edges after first sample, call_above=1, pending_cnt=1.
REQ-029 cur_floor=3, door_open=1, press hall_up_btn[3] -> up_calls unchanged; door_open=0, press again -> up_calls[3]=1, call_here=1.
REQ-030 up_calls[2]=1, cur_floor=2, serve_up pulse coincident with new hall_up_btn[2] press edge -> up_calls[2]=0.
REQ-031 Press hall_up_btn[7] and hall_dn_btn[0] -> up_calls=0, dn_calls=0, pending_cnt=0.
REQ-032 Macro defined: cab_calls[4]=1, press cab_btn[4] -> cab_calls[4]=0; macro undefined -> stays 1.
REQ-033 All 22 calls set, reset pulsed low mid-cycle -> all outputs 0 immediately, pending_cnt=0; before reset, pending_cnt=22.

Source files
------------

// File: rtl/call_registry.sv
// rtl/call_registry.sv - elevator call registry: synchronised buttons, pending-call vectors, summary outputs.
// Optional macro CALL_REGISTRY_CAB_CANCEL_EN: a repeat cab press toggles the cab call off.
module call_registry #(
  parameter int FLOORS  = 8,
  parameter int FLOOR_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic               door_open,
  input  logic [FLOORS-1:0]  cab_btn,
  input  logic [FLOORS-1:0]  hall_up_btn,
  input  logic [FLOORS-1:0]  hall_dn_btn,
  input  logic               serve_cab,
  input  logic               serve_up,
  input  logic               serve_dn,
  output logic [FLOORS-1:0]  cab_calls,
  output logic [FLOORS-1:0]  up_calls,
  output logic [FLOORS-1:0]  dn_calls,
  output logic               call_above,
  output logic               call_below,
  output logic               call_here,
  output logic [FLOOR_W+1:0] pending_cnt
);

  localparam int NB = 3 * FLOORS;
  localparam logic [FLOORS-1:0] UP_VALID = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_VALID = {{(FLOORS-1){1'b1}}, 1'b0};

  logic [NB-1:0]     btn_s1, btn_s2, btn_hist, press;
  logic [FLOORS-1:0] here_mask, above_mask, below_mask, accept_mask;
  logic [FLOORS-1:0] cab_press, up_press, dn_press;
  logic [FLOORS-1:0] cab_clr, up_clr, dn_clr;
  logic [FLOORS-1:0] cab_next, up_next, dn_next, all_calls;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_hist <= '0;
    end else begin
      btn_s1   <= {hall_dn_btn, hall_up_btn, cab_btn};
      btn_s2   <= btn_s1;
      btn_hist <= btn_s2;
    end
  end

  assign press = btn_s2 & ~btn_hist;

  // An out-of-range cur_floor yields an empty here_mask, disabling serve and blocking.
  always_comb begin
    here_mask  = '0;
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (i == int'(cur_floor)) here_mask[i]  = 1'b1;
      if (i >  int'(cur_floor)) above_mask[i] = 1'b1;
      if (i <  int'(cur_floor)) below_mask[i] = 1'b1;
    end
  end

  assign accept_mask = door_open ? ~here_mask : '1;
  assign cab_press   = press[FLOORS-1:0] & accept_mask;
  assign up_press    = press[2*FLOORS-1:FLOORS] & accept_mask & UP_VALID;
  assign dn_press    = press[NB-1:2*FLOORS] & accept_mask & DN_VALID;
  assign cab_clr     = serve_cab ? here_mask : '0;
  assign up_clr      = serve_up  ? here_mask : '0;
  assign dn_clr      = serve_dn  ? here_mask : '0;

`ifdef CALL_REGISTRY_CAB_CANCEL_EN
  assign cab_next = (cab_calls ^ cab_press) & ~cab_clr;
`else
  assign cab_next = (cab_calls | cab_press) & ~cab_clr;
`endif
  assign up_next = (up_calls | up_press) & ~up_clr;
  assign dn_next = (dn_calls | dn_press) & ~dn_clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cab_calls <= '0;
      up_calls  <= '0;
      dn_calls  <= '0;
    end else begin
      cab_calls <= cab_next;
      up_calls  <= up_next;
      dn_calls  <= dn_next;
    end
  end

  assign all_calls  = cab_calls | up_calls | dn_calls;
  assign call_above = |(all_calls & above_mask);
  assign call_below = |(all_calls & below_mask);
  assign call_here  = |(all_calls & here_mask);

  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < FLOORS; i++) begin
      pending_cnt = pending_cnt + {{(FLOOR_W+1){1'b0}}, cab_calls[i]}
                                + {{(FLOOR_W+1){1'b0}}, up_calls[i]}
                                + {{(FLOOR_W+1){1'b0}}, dn_calls[i]};
    end
  end

endmodule
